// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared state, size and byte-enable definitions for the LC-3b memory interface
package lc3_mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO = 2'b01;
  localparam logic [1:0] BE_HI = 2'b10;
  function automatic logic [1:0] be_for(input logic size, input logic a0);
    return size == SIZE_WORD ? BE_WORD : (a0 ? BE_HI : BE_LO);
  endfunction
endpackage

// File: rtl/lc3_mem_timeout.sv
// lc3_mem_timeout: busy-cycle counter that flags a request waiting too long for its acknowledge
module lc3_mem_timeout #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused;
    assign unused = &{1'b0, clk, rst, clr, en};
    assign expire = 1'b0;
  end else begin : g_on
    logic [TO_W-1:0] cnt;
    always_ff @(posedge clk) begin
      if (rst || clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
    end
    assign expire = cnt == TO_W'(TIMEOUT_CYCLES - 1);
  end
endmodule

// File: rtl/lc3_mem_if.sv
// lc3_mem_if: MAR/MDR registers and single-outstanding request/ack memory access with R pulse
module lc3_mem_if
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              mio_en,
  input  logic              r_w,
  input  logic              data_size,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] mar_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic              ready_r,
  output logic              unaligned,
  output logic              timeout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_be,
  output logic [DATA_W-2:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  state_t state;
  logic [DATA_W-1:0] mar, mdr;
  logic expire;
  assign mar_out = mar;
  assign mdr_out = mdr;
  assign mem_addr = mar[DATA_W-1:1];
  assign mem_wdata = mem_req ? mdr : '0;
  lc3_mem_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr(state != BUSY),
    .en(state == BUSY && !mem_ack),
    .expire(expire)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mar <= '0;
      mdr <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_be <= 2'b00;
      ready_r <= 1'b0;
      unaligned <= 1'b0;
      timeout <= 1'b0;
    end else begin
      ready_r <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_mar) mar <= bus_in;
          if (ld_mdr && !mio_en) mdr <= data_size == SIZE_BYTE ? {2{bus_in[DATA_W/2-1:0]}} : bus_in;
          if (mio_en) begin
            unaligned <= data_size == SIZE_WORD && mar[0];
            timeout <= 1'b0;
            if (data_size == SIZE_WORD && mar[0]) begin
              state <= DONE;
              ready_r <= 1'b1;
            end else begin
              state <= BUSY;
              mem_req <= 1'b1;
              mem_we <= r_w;
              mem_be <= be_for(data_size, mar[0]);
            end
          end
        end
        BUSY: begin
          if (mem_ack || expire) begin
            if (mem_ack && !mem_we) mdr <= mem_rdata;
            timeout <= !mem_ack;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_be <= 2'b00;
            ready_r <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lc3_mem_if.sv
// tb_lc3_mem_if: directed scenario checks of the LC-3b memory interface
module tb_lc3_mem_if;
  logic clk = 1'b0, rst = 1'b0, ld_mar = 1'b0, ld_mdr = 1'b0, mio_en = 1'b0, r_w = 1'b0, data_size = 1'b0;
  logic [15:0] bus_in = '0, mem_rdata = '0;
  logic mem_ack = 1'b0;
  logic [15:0] mar_out, mdr_out, mem_wdata;
  logic ready_r, unaligned, timeout, mem_req, mem_we;
  logic [1:0] mem_be;
  logic [14:0] mem_addr;
  int n_cmp = 0, n_err = 0;
  lc3_mem_if #(.DATA_W(16), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mio_en(mio_en), .r_w(r_w),
    .data_size(data_size), .bus_in(bus_in), .mar_out(mar_out), .mdr_out(mdr_out),
    .ready_r(ready_r), .unaligned(unaligned), .timeout(timeout), .mem_req(mem_req),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_cmp++;
    if ({mar_out, mdr_out} !== 32'h0) begin n_err++; $display("FAIL reset_regs mar=%h mdr=%h want 0000 0000", mar_out, mdr_out); end
    n_cmp++;
    if ({mem_req, mem_we, mem_be, ready_r, unaligned, timeout} !== 7'b0) begin
      n_err++; $display("FAIL reset_flags req=%b we=%b be=%b rdy=%b ua=%b to=%b want all 0", mem_req, mem_we, mem_be, ready_r, unaligned, timeout);
    end
  endtask
  task automatic test_word_read();
    ld_mar = 1'b1; bus_in = 16'h3000;
    step();
    ld_mar = 1'b0; mio_en = 1'b1; r_w = 1'b0; data_size = 1'b1;
    step();
    n_cmp++;
    if ({mem_req, mem_we, mem_be, ready_r, mem_addr} !== {1'b1, 1'b0, 2'b11, 1'b0, 15'h1800}) begin
      n_err++; $display("FAIL wr_busy req=%b we=%b be=%b rdy=%b addr=%h want 1 0 11 0 1800", mem_req, mem_we, mem_be, ready_r, mem_addr);
    end
    mio_en = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step();
    mem_ack = 1'b0;
    n_cmp++;
    if ({ready_r, mem_req, mdr_out} !== {1'b1, 1'b0, 16'hBEEF}) begin
      n_err++; $display("FAIL wr_done rdy=%b req=%b mdr=%h want 1 0 beef", ready_r, mem_req, mdr_out);
    end
    step();
    n_cmp++;
    if (ready_r !== 1'b0) begin n_err++; $display("FAIL wr_rdy_pulse rdy=%b want 0", ready_r); end
  endtask
  task automatic test_byte_write();
    ld_mar = 1'b1; bus_in = 16'h4001;
    step();
    ld_mar = 1'b0; ld_mdr = 1'b1; bus_in = 16'h00A5; data_size = 1'b0;
    step();
    ld_mdr = 1'b0;
    n_cmp++;
    if ({mar_out, mdr_out} !== {16'h4001, 16'hA5A5}) begin n_err++; $display("FAIL bw_load mar=%h mdr=%h want 4001 a5a5", mar_out, mdr_out); end
    mio_en = 1'b1; r_w = 1'b1;
    step();
    mio_en = 1'b0; mem_rdata = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({mem_req, mem_we, mem_be, ready_r, mem_wdata, mem_addr} !== {1'b1, 1'b1, 2'b10, 1'b0, 16'hA5A5, 15'h2000}) begin
        n_err++; $display("FAIL bw_busy%0d req=%b we=%b be=%b rdy=%b wd=%h addr=%h want 1 1 10 0 a5a5 2000", i, mem_req, mem_we, mem_be, ready_r, mem_wdata, mem_addr);
      end
      if (i == 3) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    n_cmp++;
    if ({ready_r, mem_req, timeout, mdr_out} !== {1'b1, 1'b0, 1'b0, 16'hA5A5}) begin
      n_err++; $display("FAIL bw_done rdy=%b req=%b to=%b mdr=%h want 1 0 0 a5a5", ready_r, mem_req, timeout, mdr_out);
    end
    step();
  endtask
  task automatic test_unaligned();
    ld_mar = 1'b1; bus_in = 16'h2003;
    step();
    ld_mar = 1'b0; mio_en = 1'b1; data_size = 1'b1; r_w = 1'b0;
    step();
    n_cmp++;
    if ({mem_req, unaligned, ready_r} !== 3'b011) begin n_err++; $display("FAIL ua_done req=%b ua=%b rdy=%b want 0 1 1", mem_req, unaligned, ready_r); end
    step();
    mio_en = 1'b0;
    n_cmp++;
    if ({mem_req, unaligned, ready_r} !== 3'b010) begin n_err++; $display("FAIL ua_idle req=%b ua=%b rdy=%b want 0 1 0", mem_req, unaligned, ready_r); end
    ld_mar = 1'b1; bus_in = 16'h2004;
    step();
    ld_mar = 1'b0; mio_en = 1'b1; data_size = 1'b0;
    step();
    mio_en = 1'b0;
    n_cmp++;
    if ({mem_req, unaligned, mem_be} !== 4'b1001) begin n_err++; $display("FAIL ua_clear req=%b ua=%b be=%b want 1 0 01", mem_req, unaligned, mem_be); end
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    step();
    mem_ack = 1'b0;
    n_cmp++;
    if ({ready_r, mdr_out} !== {1'b1, 16'h5A5A}) begin n_err++; $display("FAIL ua_byte_read rdy=%b mdr=%h want 1 5a5a", ready_r, mdr_out); end
    step();
  endtask
  task automatic test_back_to_back();
    mio_en = 1'b1; data_size = 1'b1; r_w = 1'b0;
    step();
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    step();
    mem_ack = 1'b0;
    n_cmp++;
    if ({ready_r, mdr_out} !== {1'b1, 16'h1111}) begin n_err++; $display("FAIL b2b_first rdy=%b mdr=%h want 1 1111", ready_r, mdr_out); end
    step();
    n_cmp++;
    if ({mem_req, ready_r} !== 2'b00) begin n_err++; $display("FAIL b2b_gap req=%b rdy=%b want 0 0", mem_req, ready_r); end
    step();
    n_cmp++;
    if (mem_req !== 1'b1) begin n_err++; $display("FAIL b2b_restart req=%b want 1", mem_req); end
    mio_en = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h2222;
    step();
    mem_ack = 1'b0;
    n_cmp++;
    if ({ready_r, mdr_out} !== {1'b1, 16'h2222}) begin n_err++; $display("FAIL b2b_second rdy=%b mdr=%h want 1 2222", ready_r, mdr_out); end
    step();
  endtask
  task automatic test_timeout();
    mio_en = 1'b1; data_size = 1'b1; r_w = 1'b0;
    step();
    mio_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({mem_req, timeout, ready_r} !== 3'b100) begin n_err++; $display("FAIL to_busy%0d req=%b to=%b rdy=%b want 1 0 0", i, mem_req, timeout, ready_r); end
      step();
    end
    n_cmp++;
    if ({mem_req, timeout, ready_r, mdr_out} !== {3'b011, 16'h2222}) begin
      n_err++; $display("FAIL to_done req=%b to=%b rdy=%b mdr=%h want 0 1 1 2222", mem_req, timeout, ready_r, mdr_out);
    end
    step();
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    step();
    mem_ack = 1'b0;
    n_cmp++;
    if ({mem_req, ready_r, timeout, mdr_out} !== {3'b001, 16'h2222}) begin
      n_err++; $display("FAIL to_late_ack req=%b rdy=%b to=%b mdr=%h want 0 0 1 2222", mem_req, ready_r, timeout, mdr_out);
    end
  endtask
  task automatic test_ignored_loads_reset();
    ld_mar = 1'b1; ld_mdr = 1'b1; data_size = 1'b1; bus_in = 16'h1356;
    step();
    ld_mdr = 1'b0; ld_mar = 1'b0;
    n_cmp++;
    if ({mar_out, mdr_out} !== {16'h1356, 16'h1356}) begin n_err++; $display("FAIL dual_load mar=%h mdr=%h want 1356 1356", mar_out, mdr_out); end
    mio_en = 1'b1;
    step();
    mio_en = 1'b0; ld_mar = 1'b1; ld_mdr = 1'b1; bus_in = 16'hFFFF;
    step();
    ld_mar = 1'b0; ld_mdr = 1'b0;
    n_cmp++;
    if ({mem_req, mar_out, mdr_out, mem_addr} !== {1'b1, 16'h1356, 16'h1356, 15'h09AB}) begin
      n_err++; $display("FAIL busy_ignore req=%b mar=%h mdr=%h addr=%h want 1 1356 1356 09ab", mem_req, mar_out, mdr_out, mem_addr);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({mem_req, mem_we, mem_be, ready_r, unaligned, timeout, mar_out, mdr_out} !== 39'b0) begin
      n_err++; $display("FAIL rst_busy req=%b be=%b rdy=%b mar=%h mdr=%h want all 0", mem_req, mem_be, ready_r, mar_out, mdr_out);
    end
    mem_ack = 1'b1; mem_rdata = 16'hCAFE;
    step();
    mem_ack = 1'b0;
    n_cmp++;
    if ({mem_req, ready_r, mdr_out} !== 18'b0) begin n_err++; $display("FAIL stale_ack req=%b rdy=%b mdr=%h want 0 0 0000", mem_req, ready_r, mdr_out); end
  endtask
  initial begin
    test_reset();
    test_word_read();
    test_byte_write();
    test_unaligned();
    test_back_to_back();
    test_timeout();
    test_ignored_loads_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lc3_mem_if.md
Name: lc3_mem_if

Overview:
- Memory-side consumer of the effective address produced by the address adder: latches the address into MAR and data into MDR.
- Runs a single-outstanding request/acknowledge transaction to a multi-cycle memory.
- Returns the R (ready) indication to the microsequencer.
- Handles LC-3b byte/word sizing, unaligned-word detection and a no-acknowledge timeout.

Parameters:
- DATA_W, 16, datapath and memory word width (fixed 16 for LC-3b; parameter for bench reuse)
- TIMEOUT_CYCLES, 64, max busy cycles without mem_ack before abort; 0 disables timeout
- TO_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- ld_mar  input  1  load MAR from bus_in
- ld_mdr  input  1  load MDR from bus_in (only when mio_en=0)
- mio_en  input  1  start memory access (level, from control store)
- r_w  input  1  1=write, 0=read
- data_size  input  1  1=word, 0=byte
- bus_in  input  16  system bus value
- mar_out  output  16  current MAR
- mdr_out  output  16  current MDR
- ready_r  output  1  one-cycle R pulse at access end
- unaligned  output  1  sticky: last access was word with MAR[0]=1
- timeout  output  1  sticky: last access aborted on timeout
- mem_req  output  1  request, held until ack or abort
- mem_we  output  1  write strobe, valid with mem_req
- mem_be  output  2  byte enables {hi,lo}, valid with mem_req
- mem_addr  output  15  word address = MAR[15:1]
- mem_wdata  output  16  = MDR while mem_req
- mem_rdata  input  16  read data, valid with mem_ack
- mem_ack  input  1  memory completion, sampled only while mem_req=1

Behaviour:
- Reset values:
  - mar=0, mdr=0, state IDLE
  - mem_req=0, mem_we=0, mem_be=0
  - ready_r=0, unaligned=0, timeout=0
  - timeout counter=0
  - rst mid-access drops mem_req at that edge; a late mem_ack is ignored.
- States: IDLE, BUSY, DONE.
- IDLE:
  - ld_mar=1: mar<=bus_in.
  - ld_mdr=1 and mio_en=0, word: mdr<=bus_in.
  - ld_mdr=1 and mio_en=0, byte: mdr<={bus_in[7:0],bus_in[7:0]} (lane replication for STB).
  - ld_mar and ld_mdr in the same cycle: both load.
  - mio_en=1: clear unaligned and timeout.
    - data_size=1 and mar[0]=1: set unaligned, go DONE, no request.
    - Otherwise: go BUSY; mem_req=1, mem_we=r_w.
    - mem_be=11 for word, 01 if mar[0]=0 byte, 10 if mar[0]=1 byte.
    - Counter cleared.
- BUSY:
  - mem_req, mem_we, mem_be, mem_addr and mem_wdata held stable.
  - ld_mar and ld_mdr are ignored.
  - mem_ack=1:
    - Read: mdr<=mem_rdata (full word; byte select is downstream).
    - Write: mdr unchanged.
    - Deassert mem_req next edge; go DONE.
  - No ack: counter++. When TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1, set timeout, drop mem_req, go DONE, mdr unchanged.
  - mio_en deasserting in BUSY does not abort; the access completes.
- DONE:
  - ready_r=1 for exactly this cycle, mem_req=0.
  - Next state is IDLE unconditionally. mio_en still high does not retrigger until IDLE is sampled, so back-to-back accesses have a 1-cycle gap.
- Latency from mio_en sampled in IDLE:
  - Zero-wait memory (ack in first BUSY cycle): ready_r 2 cycles later.
  - N wait cycles: 2+N.
  - Unaligned: 1.
  - Timeout: TIMEOUT_CYCLES+1.
- mar_out and mdr_out are registered outputs. mem_addr is combinational from mar.

Decomposition:
- Package lc3_mem_pkg:
  - State enum {IDLE, BUSY, DONE}.
  - SIZE_BYTE=0, SIZE_WORD=1.
  - BE_WORD=2'b11, BE_LO=2'b01, BE_HI=2'b10.
- One sub-module, lc3_mem_timeout:
  - Clear/enable counter with expire output.
  - Tied off when TIMEOUT_CYCLES=0.
- FSM and MAR/MDR registers stay in lc3_mem_if.

Test Plan:
- Word read, zero-wait: bus_in=0x3000 with ld_mar; mio_en, r_w=0, size=1; ack next cycle with rdata=0xBEEF.
  - Expect mem_addr=0x1800, be=11, ready_r 2 cycles after start, mdr_out=0xBEEF.
- Byte write to odd address: mar=0x4001; ld_mdr bus=0x00A5, size=0; then mio_en, r_w=1; memory acks after 3 wait cycles.
  - Expect mdr=0xA5A5, mem_we=1, be=10, req held 4 cycles, ready_r at cycle 5.
- Unaligned word: mar=0x2003, mio_en, size=1.
  - Expect no mem_req, unaligned=1, ready_r next cycle.
  - Unaligned clears at the next access start.
- Timeout with TIMEOUT_CYCLES=4, never ack.
  - Expect req high 4 cycles, then timeout=1, ready_r pulse, mdr unchanged.
  - An ack arriving 2 cycles later is ignored.
- Ignored loads and reset: ld_mar=1 bus=0xFFFF during BUSY leaves mar unchanged. Then rst in BUSY.
  - Expect mem_req=0 next cycle and all outputs at reset values.
  - A stale mem_ack after reset does not change mdr.
